// File: rtl/uart_bus_pkg.sv
`default_nettype none
// ============================================================================
// Package     : uart_bus_pkg
// Description : Register map, STATUS/CTRL bit positions and shared UART FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_bus_pkg;

    localparam logic [3:0] OFF_TXD    = 4'h0;
    localparam logic [3:0] OFF_RXD    = 4'h4;
    localparam logic [3:0] OFF_STATUS = 4'h8;
    localparam logic [3:0] OFF_CTRL   = 4'hC;

    localparam int ST_TX_FULL    = 0;
    localparam int ST_TX_BUSY    = 1;
    localparam int ST_RX_VALID   = 2;
    localparam int ST_RX_OVERRUN = 3;
    localparam int ST_FRAME_ERR  = 4;
    localparam int ST_TX_DROP    = 5;
    localparam int ST_TX_DONE    = 6;

    localparam int CTRL_RX_IRQ_EN      = 0;
    localparam int CTRL_TX_DONE_IRQ_EN = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_bus_slave_if.sv
`default_nettype none
// ============================================================================
// Interface   : uart_bus_slave_if
// Description : CPU data-bus strobe/request/data bundle seen by the UART.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_bus_slave_if;
    logic        stb;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output stb, rd, wr, addr, wdata, input  rdata);
    modport slave  (input  stb, rd, wr, addr, wdata, output rdata);
endinterface
`default_nettype wire

// File: rtl/byte_fifo.sv
`default_nettype none
// ============================================================================
// Module      : byte_fifo
// Description : Synchronous 8-bit FIFO; a pop on a full FIFO frees room for a same-cycle push.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_fifo #(
    parameter int DEPTH = 4
) (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       i_push,
    input  wire logic       i_pop,
    input  wire logic [7:0] i_data,
    output logic      [7:0] o_head,
    output logic            o_full,
    output logic            o_empty
);
    localparam int c_AW = $clog2(DEPTH);

    logic [7:0]  r_mem [DEPTH];
    logic [c_AW:0] r_wp;
    logic [c_AW:0] r_rp;
    logic        w_do_pop;
    logic        w_do_push;

    // Extra pointer bit tells full from empty once the indices wrap.
    assign o_empty   = (r_wp == r_rp);
    assign o_full    = (r_wp[c_AW] != r_rp[c_AW]) && (r_wp[c_AW-1:0] == r_rp[c_AW-1:0]);
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_head    = r_mem[r_rp[c_AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_do_push) r_wp <= r_wp + 1'b1;
            if (w_do_pop)  r_rp <= r_rp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wp[c_AW-1:0]] <= i_data;
    end
endmodule
`default_nettype wire

// File: rtl/uart_bus_slave.sv
`default_nettype none
// ============================================================================
// Module      : uart_bus_slave
// Description : Memory-mapped 8N1 UART with TX/RX byte FIFOs, sticky status and IRQ.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_bus_slave
    import uart_bus_pkg::*;
#(
    parameter int          CLK_FREQ   = 100000000,
    parameter int          BAUD       = 9600,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h40000020
) (
    input  wire logic       sysclk,
    input  wire logic       reset,
    uart_bus_slave_if.slave bus,
    input  wire logic       uart_rx,
    output logic            uart_tx,
    output logic            irqout
);
    localparam int c_BIT_CLKS = CLK_FREQ / BAUD;
    localparam int c_CW       = $clog2(c_BIT_CLKS);
    localparam logic [c_CW-1:0] c_BIT_LAST  = c_CW'(c_BIT_CLKS - 1);
    localparam logic [c_CW-1:0] c_HALF_LAST = c_CW'(c_BIT_CLKS / 2 - 1);

    logic w_hit, w_wr, w_rd, w_tx_push, w_rx_pop, w_st_wr;
    logic [3:0] w_off;
    logic [7:0] w_tx_head, w_rx_head;
    logic w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
    logic [31:0] w_status;
    logic [1:0] r_ctrl;
    logic r_rx_overrun, r_frame_err, r_tx_drop, r_tx_done, r_irq;

    assign w_hit     = (bus.addr[31:4] == BASE_ADDR[31:4]);
    assign w_off     = {bus.addr[3:2], 2'b00};
    assign w_wr      = bus.stb & w_hit & bus.wr;
    assign w_rd      = bus.stb & w_hit & bus.rd & ~bus.wr;
    assign w_tx_push = w_wr && (w_off == OFF_TXD);
    assign w_rx_pop  = w_rd && (w_off == OFF_RXD);
    assign w_st_wr   = w_wr && (w_off == OFF_STATUS);

    wire w_unused = &{1'b0, bus.addr[1:0], bus.wdata[31:8]};

    // ---------------- transmitter ----------------
    uart_state_e r_tx_state, w_tx_state_n;
    logic [c_CW-1:0] r_tx_cnt, w_tx_cnt_n;
    logic [2:0] r_tx_bit, w_tx_bit_n;
    logic [7:0] r_tx_shift, w_tx_shift_n;
    logic r_tx_line, w_tx_line_n, w_tx_pop, w_tx_done_set;

    always_comb begin
        w_tx_state_n  = r_tx_state;
        w_tx_cnt_n    = r_tx_cnt + 1'b1;
        w_tx_bit_n    = r_tx_bit;
        w_tx_pop      = 1'b0;
        w_tx_done_set = 1'b0;
        case (r_tx_state)
            IDLE: begin
                w_tx_cnt_n = '0;
                if (!w_tx_empty) begin
                    w_tx_pop     = 1'b1;
                    w_tx_state_n = START;
                end
            end
            START: if (r_tx_cnt == c_BIT_LAST) begin
                w_tx_cnt_n   = '0;
                w_tx_bit_n   = 3'd0;
                w_tx_state_n = DATA;
            end
            DATA: if (r_tx_cnt == c_BIT_LAST) begin
                w_tx_cnt_n = '0;
                if (r_tx_bit == 3'd7) w_tx_state_n = STOP;
                else                  w_tx_bit_n   = r_tx_bit + 3'd1;
            end
            STOP: if (r_tx_cnt == c_BIT_LAST) begin
                w_tx_cnt_n = '0;
                // Chain straight into the next start bit so frames abut.
                if (!w_tx_empty) begin
                    w_tx_pop     = 1'b1;
                    w_tx_state_n = START;
                end else begin
                    w_tx_state_n  = IDLE;
                    w_tx_done_set = 1'b1;
                end
            end
            default: w_tx_state_n = IDLE;
        endcase
        w_tx_shift_n = w_tx_pop ? w_tx_head : r_tx_shift;
        w_tx_line_n  = 1'b1;
        case (w_tx_state_n)
            START:   w_tx_line_n = 1'b0;
            DATA:    w_tx_line_n = w_tx_shift_n[w_tx_bit_n];
            default: w_tx_line_n = 1'b1;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_tx_state <= IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx_line  <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_n;
            r_tx_cnt   <= w_tx_cnt_n;
            r_tx_bit   <= w_tx_bit_n;
            r_tx_shift <= w_tx_shift_n;
            r_tx_line  <= w_tx_line_n;
        end
    end

    assign uart_tx = r_tx_line;

    // ---------------- receiver ----------------
    uart_state_e r_rx_state, w_rx_state_n;
    logic [c_CW-1:0] r_rx_cnt, w_rx_cnt_n;
    logic [2:0] r_rx_bit, w_rx_bit_n;
    logic [7:0] r_rx_shift, w_rx_shift_n;
    logic [1:0] r_rx_sync;
    logic w_rx_s, w_rx_push, w_ferr_set;

    assign w_rx_s = r_rx_sync[1];

    always_comb begin
        w_rx_state_n = r_rx_state;
        w_rx_cnt_n   = r_rx_cnt + 1'b1;
        w_rx_bit_n   = r_rx_bit;
        w_rx_shift_n = r_rx_shift;
        w_rx_push    = 1'b0;
        w_ferr_set   = 1'b0;
        case (r_rx_state)
            IDLE: begin
                w_rx_cnt_n = '0;
                if (!w_rx_s) w_rx_state_n = START;
            end
            START: if (r_rx_cnt == c_HALF_LAST) begin
                w_rx_cnt_n   = '0;
                w_rx_bit_n   = 3'd0;
                w_rx_state_n = w_rx_s ? IDLE : DATA;
            end
            DATA: if (r_rx_cnt == c_BIT_LAST) begin
                w_rx_cnt_n   = '0;
                w_rx_shift_n = {w_rx_s, r_rx_shift[7:1]};
                if (r_rx_bit == 3'd7) w_rx_state_n = STOP;
                else                  w_rx_bit_n   = r_rx_bit + 3'd1;
            end
            STOP: if (r_rx_cnt == c_BIT_LAST) begin
                w_rx_cnt_n   = '0;
                w_rx_state_n = IDLE;
                w_rx_push    = w_rx_s;
                w_ferr_set   = ~w_rx_s;
            end
            default: w_rx_state_n = IDLE;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_rx_state <= IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_sync  <= 2'b11;
        end else begin
            r_rx_state <= w_rx_state_n;
            r_rx_cnt   <= w_rx_cnt_n;
            r_rx_bit   <= w_rx_bit_n;
            r_rx_shift <= w_rx_shift_n;
            r_rx_sync  <= {r_rx_sync[0], uart_rx};
        end
    end

    // ---------------- FIFOs ----------------
    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(sysclk), .rst(reset), .i_push(w_tx_push), .i_pop(w_tx_pop),
        .i_data(bus.wdata[7:0]), .o_head(w_tx_head), .o_full(w_tx_full), .o_empty(w_tx_empty)
    );

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(sysclk), .rst(reset), .i_push(w_rx_push), .i_pop(w_rx_pop),
        .i_data(r_rx_shift), .o_head(w_rx_head), .o_full(w_rx_full), .o_empty(w_rx_empty)
    );

    // ---------------- registers, flags, IRQ ----------------
    always_comb begin
        w_status                = '0;
        w_status[ST_TX_FULL]    = w_tx_full;
        w_status[ST_TX_BUSY]    = (r_tx_state != IDLE) | ~w_tx_empty;
        w_status[ST_RX_VALID]   = ~w_rx_empty;
        w_status[ST_RX_OVERRUN] = r_rx_overrun;
        w_status[ST_FRAME_ERR]  = r_frame_err;
        w_status[ST_TX_DROP]    = r_tx_drop;
        w_status[ST_TX_DONE]    = r_tx_done;
    end

    always_comb begin
        bus.rdata = '0;
        if (bus.rd && w_hit) begin
            case (w_off)
                OFF_RXD:    if (!w_rx_empty) bus.rdata = {24'd0, w_rx_head};
                OFF_STATUS: bus.rdata = w_status;
                OFF_CTRL:   bus.rdata = {30'd0, r_ctrl};
                default:    bus.rdata = '0;
            endcase
        end
    end

    // A set in the same cycle as its w1c clear keeps the flag.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_ctrl       <= '0;
            r_rx_overrun <= 1'b0;
            r_frame_err  <= 1'b0;
            r_tx_drop    <= 1'b0;
            r_tx_done    <= 1'b0;
            r_irq        <= 1'b0;
        end else begin
            if (w_wr && (w_off == OFF_CTRL)) r_ctrl <= bus.wdata[1:0];
            r_rx_overrun <= (w_rx_push & w_rx_full & ~w_rx_pop)
                          | (r_rx_overrun & ~(w_st_wr & bus.wdata[ST_RX_OVERRUN]));
            r_frame_err  <= w_ferr_set | (r_frame_err & ~(w_st_wr & bus.wdata[ST_FRAME_ERR]));
            r_tx_drop    <= (w_tx_push & w_tx_full & ~w_tx_pop)
                          | (r_tx_drop & ~(w_st_wr & bus.wdata[ST_TX_DROP]));
            r_tx_done    <= w_tx_done_set | (r_tx_done & ~(w_st_wr & bus.wdata[ST_TX_DONE]));
            r_irq        <= (~w_rx_empty & r_ctrl[CTRL_RX_IRQ_EN])
                          | (r_tx_done & r_ctrl[CTRL_TX_DONE_IRQ_EN]);
        end
    end

    assign irqout = r_irq;
endmodule
`default_nettype wire

// File: tb/tb_uart_bus_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_bus_slave
// Description : Scoreboard bench for uart_bus_slave (BIT_CLKS = 16, depth 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_bus_slave;
    localparam logic [31:0] c_BASE = 32'h40000020;
    localparam logic [31:0] c_TXD  = c_BASE;
    localparam logic [31:0] c_RXD  = c_BASE + 32'h4;
    localparam logic [31:0] c_ST   = c_BASE + 32'h8;
    localparam logic [31:0] c_CTRL = c_BASE + 32'hC;

    logic sysclk = 1'b0;
    logic reset  = 1'b1;
    logic uart_rx = 1'b1;
    logic uart_tx;
    logic irqout;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit mon_on   = 1'b0;
    bit tx_ign   = 1'b0;
    int rx_cnt   = 0;
    logic [7:0] tx_exp[$];
    logic [7:0] rx_exp[$];
    int         tx_starts[$];

    uart_bus_slave_if bus();

    uart_bus_slave #(
        .CLK_FREQ(160), .BAUD(10), .FIFO_DEPTH(4), .BASE_ADDR(c_BASE)
    ) dut (
        .sysclk(sysclk), .reset(reset), .bus(bus),
        .uart_rx(uart_rx), .uart_tx(uart_tx), .irqout(irqout)
    );

    always #5 sysclk = ~sysclk;
    always @(posedge sysclk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge sysclk);
            #1;
        end
    endtask

    task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
        bus.stb = 1'b1; bus.wr = 1'b1; bus.rd = 1'b0; bus.addr = a; bus.wdata = d;
        tick(1);
        bus.stb = 1'b0; bus.wr = 1'b0;
    endtask

    task automatic rd_reg(input logic [31:0] a, output logic [31:0] d);
        bus.stb = 1'b1; bus.rd = 1'b1; bus.wr = 1'b0; bus.addr = a;
        #1;
        d = bus.rdata;
        tick(1);
        bus.stb = 1'b0; bus.rd = 1'b0;
    endtask

    task automatic rd_chk(input logic [31:0] a, input logic [31:0] exp, input string tag);
        logic [31:0] d;
        rd_reg(a, d);
        check_eq(tag, d, exp);
    endtask

    task automatic rd_rxd(input string tag);
        logic [31:0] d;
        logic [31:0] e;
        e = 32'd0;
        if (rx_exp.size() > 0) begin
            e = {24'd0, rx_exp.pop_front()};
            rx_cnt--;
        end
        rd_reg(c_RXD, d);
        check_eq(tag, d, e);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0;
        tick(16);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            tick(16);
        end
        uart_rx = stop_bit;
        tick(16);
        uart_rx = 1'b1;
        if (stop_bit && rx_cnt < 4) begin
            rx_exp.push_back(b);
            rx_cnt++;
        end
    endtask

    initial begin : tx_mon
        logic [7:0]  b;
        logic        sb;
        logic        pb;
        int          st;
        logic [31:0] exp;
        wait (mon_on);
        forever begin
            @(negedge sysclk);
            if (uart_tx === 1'b0) begin
                st = cyc;
                repeat (8) @(negedge sysclk);
                sb = uart_tx;
                for (int i = 0; i < 8; i++) begin
                    repeat (16) @(negedge sysclk);
                    b[i] = uart_tx;
                end
                repeat (16) @(negedge sysclk);
                pb = uart_tx;
                if (tx_ign) begin
                    tx_ign = 1'b0;
                end else begin
                    exp = (tx_exp.size() > 0) ? {22'd0, 1'b0, tx_exp.pop_front(), 1'b1} : 32'hFFFFFFFF;
                    check_eq("tx_frame", {22'd0, sb, b, pb}, exp);
                    tx_starts.push_back(st);
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation timeout");
    end

    initial begin : main
        int t0;
        int n;
        bus.stb = 1'b0; bus.rd = 1'b0; bus.wr = 1'b0; bus.addr = '0; bus.wdata = '0;
        reset = 1'b1;
        tick(3);
        reset = 1'b0;

        check_eq("rst_tx_line", {31'd0, uart_tx}, 32'd1);
        check_eq("rst_irq", {31'd0, irqout}, 32'd0);
        check_eq("rdata_idle", bus.rdata, 32'd0);
        rd_chk(c_ST, 32'h0, "rst_status");
        rd_chk(c_CTRL, 32'h0, "rst_ctrl");
        rd_chk(c_TXD, 32'h0, "txd_reads_zero");
        wr_reg(32'h4000003C, 32'h3);
        rd_chk(c_CTRL, 32'h0, "ctrl_miss_decode");
        mon_on = 1'b1;

        // single transmit
        tx_exp.push_back(8'h55);
        t0 = cyc;
        wr_reg(c_TXD, 32'h55);
        for (int i = 0; i < 10 && uart_tx !== 1'b0; i++) @(negedge sysclk);
        n = 0;
        while (uart_tx === 1'b0 && n < 40) begin
            n++;
            @(negedge sysclk);
        end
        check_eq("tx_start_len", n, 32'd16);
        wait_cyc(t0 + 140);
        rd_chk(c_ST, 32'h02, "tx_busy_mid");
        wait_cyc(t0 + 170);
        rd_chk(c_ST, 32'h40, "tx_done");
        wr_reg(c_ST, 32'h40);
        rd_chk(c_ST, 32'h0, "tx_done_w1c");

        // single receive
        send_frame(8'hA3, 1'b1);
        tick(4);
        rd_chk(c_ST, 32'h04, "rx_valid");
        rd_rxd("rxd_a3");
        rd_rxd("rxd_empty");
        rd_chk(c_ST, 32'h0, "rx_drained");

        // receive interrupt
        wr_reg(c_CTRL, 32'h1);
        rd_chk(c_CTRL, 32'h1, "ctrl_rw");
        check_eq("irq_idle", {31'd0, irqout}, 32'd0);
        send_frame(8'h3C, 1'b1);
        tick(2);
        check_eq("irq_rx", {31'd0, irqout}, 32'd1);
        rd_rxd("rxd_3c");
        check_eq("irq_hold", {31'd0, irqout}, 32'd1);
        tick(1);
        check_eq("irq_fall", {31'd0, irqout}, 32'd0);
        wr_reg(c_CTRL, 32'h0);

        // framing error and glitch
        send_frame(8'h5A, 1'b0);
        tick(20);
        rd_chk(c_ST, 32'h10, "frame_err");
        wr_reg(c_ST, 32'h10);
        rd_chk(c_ST, 32'h0, "frame_err_w1c");
        uart_rx = 1'b0;
        tick(4);
        uart_rx = 1'b1;
        tick(40);
        rd_chk(c_ST, 32'h0, "glitch_ignored");

        // receive overrun
        for (int i = 1; i <= 5; i++) send_frame(8'(i * 8'h11), 1'b1);
        tick(4);
        rd_chk(c_ST, 32'h0C, "rx_overrun");
        for (int i = 0; i < 4; i++) rd_rxd("rxd_ovr_order");
        rd_chk(c_ST, 32'h08, "ovr_sticky");
        wr_reg(c_ST, 32'h08);
        rd_chk(c_ST, 32'h0, "ovr_w1c");

        // transmit saturation
        tx_starts.delete();
        for (int i = 1; i <= 6; i++) begin
            if (i <= 5) tx_exp.push_back(8'(i));
            wr_reg(c_TXD, i);
        end
        rd_chk(c_ST, 32'h23, "tx_sat_status");
        wait_cyc(cyc + 5 * 160 + 40);
        check_eq("tx_sat_frames", tx_starts.size(), 32'd5);
        for (int i = 1; i < tx_starts.size(); i++)
            check_eq("tx_no_gap", tx_starts[i] - tx_starts[i-1], 32'd160);
        check_eq("tx_sat_drained", tx_exp.size(), 32'd0);
        rd_chk(c_ST, 32'h60, "tx_sat_done");
        wr_reg(c_ST, 32'h60);
        rd_chk(c_ST, 32'h0, "tx_sat_w1c");

        // reset in the middle of a transmit
        wr_reg(c_CTRL, 32'h3);
        tx_ign = 1'b1;
        t0 = cyc;
        wr_reg(c_TXD, 32'hF0);
        wait_cyc(t0 + 74);
        check_eq("tx_bit3_low", {31'd0, uart_tx}, 32'd0);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check_eq("rst_mid_line", {31'd0, uart_tx}, 32'd1);
        rd_chk(c_ST, 32'h0, "rst_mid_status");
        rd_chk(c_CTRL, 32'h0, "rst_mid_ctrl");
        tick(200);
        tx_exp.push_back(8'hC5);
        wr_reg(c_TXD, 32'hC5);
        tick(200);
        check_eq("tx_after_rst_drained", tx_exp.size(), 32'd0);
        rd_chk(c_ST, 32'h40, "tx_after_rst_done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
